// File: rtl/lab4_task_sequencer.sv
// lab4_task_sequencer
//   Shares one operand bus, one start key and the HEX1/HEX0 display pair
//   between the two lab 4 engines (bitcounter and BinarySearch).
//   On a rising edge of start_req the mode and the operand are latched. After
//   one settling cycle, exactly one engine's start level is raised. The
//   sequencer then waits, with a cycle budget, for that engine's done and
//   holds the captured result for the seven-segment display.
//
// Ports
//   clock                   system clock (CLOCK_50)
//   reset                   synchronous, active-high
//   start_req               synchronized start level (~KEY[3] after a DFF)
//   mode                    0 = bit count, 1 = binary search (SW[8])
//   data_in                 operand (SW[7:0])
//   eng_a                   latched operand, fanned out to both engines
//   bc_start / bs_start     engine start levels (never both high)
//   bc_done, bc_result      bitcounter handshake and result
//   bs_done, bs_found,
//   bs_loc                  BinarySearch handshake and result
//   busy                    high while dispatching or running
//   res_valid               high while a fresh result is being held
//   hex0_val, hex1_val      digits for HEX0 / HEX1
//   hex1_on                 1 = HEX1 shows hex1_val, 0 = HEX1 blank
//   show_dash               1 = display shows '-' (not found or timeout)
//   error                   timeout flag, sticky until reset or next start
module lab4_task_sequencer #(
  parameter int DATA_W  = 8,
  parameter int LOC_W   = 5,
  parameter int CNT_W   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start_req,
  input  logic              mode,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] eng_a,
  output logic              bc_start,
  input  logic              bc_done,
  input  logic [CNT_W-1:0]  bc_result,
  output logic              bs_start,
  input  logic              bs_done,
  input  logic              bs_found,
  input  logic [LOC_W-1:0]  bs_loc,
  output logic              busy,
  output logic              res_valid,
  output logic [3:0]        hex0_val,
  output logic [3:0]        hex1_val,
  output logic              hex1_on,
  output logic              show_dash,
  output logic              error
);

  localparam int TO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_DISPATCH = 3'd1,
    S_RUN      = 3'd2,
    S_HOLD     = 3'd3,
    S_ERROR    = 3'd4
  } state_t;

  state_t            state_r, state_nxt_s;
  logic [TO_W-1:0]   cnt_r, cnt_nxt_s;
  logic              start_prev_r;
  logic              mode_q_r, mode_q_nxt_s;
  logic [DATA_W-1:0] eng_a_r, eng_a_nxt_s;
  logic              bc_start_r, bc_start_nxt_s;
  logic              bs_start_r, bs_start_nxt_s;
  logic              busy_r, busy_nxt_s;
  logic              res_valid_r, res_valid_nxt_s;
  logic [3:0]        hex0_r, hex0_nxt_s;
  logic [3:0]        hex1_r, hex1_nxt_s;
  logic              hex1_on_r, hex1_on_nxt_s;
  logic              show_dash_r, show_dash_nxt_s;
  logic              error_r, error_nxt_s;
  logic              start_edge_s;
  logic              sel_done_s;

  assign start_edge_s = start_req & ~start_prev_r;
  // Only the engine chosen at latch time can finish the run.
  assign sel_done_s   = mode_q_r ? bs_done : bc_done;

  // State, counter and registered outputs; reset clears everything at once.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r      <= S_IDLE;
      cnt_r        <= '0;
      // Track the key during reset so a level held through reset is not an edge.
      start_prev_r <= start_req;
      mode_q_r     <= 1'b0;
      eng_a_r      <= '0;
      bc_start_r   <= 1'b0;
      bs_start_r   <= 1'b0;
      busy_r       <= 1'b0;
      res_valid_r  <= 1'b0;
      hex0_r       <= 4'h0;
      hex1_r       <= 4'h0;
      hex1_on_r    <= 1'b0;
      show_dash_r  <= 1'b0;
      error_r      <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      cnt_r        <= cnt_nxt_s;
      start_prev_r <= start_req;
      mode_q_r     <= mode_q_nxt_s;
      eng_a_r      <= eng_a_nxt_s;
      bc_start_r   <= bc_start_nxt_s;
      bs_start_r   <= bs_start_nxt_s;
      busy_r       <= busy_nxt_s;
      res_valid_r  <= res_valid_nxt_s;
      hex0_r       <= hex0_nxt_s;
      hex1_r       <= hex1_nxt_s;
      hex1_on_r    <= hex1_on_nxt_s;
      show_dash_r  <= show_dash_nxt_s;
      error_r      <= error_nxt_s;
    end
  end

  // Next-state logic; status outputs are derived from the next state so they
  // line up with the registered state.
  always_comb begin
    state_nxt_s     = state_r;
    cnt_nxt_s       = cnt_r;
    mode_q_nxt_s    = mode_q_r;
    eng_a_nxt_s     = eng_a_r;
    hex0_nxt_s      = hex0_r;
    hex1_nxt_s      = hex1_r;
    hex1_on_nxt_s   = hex1_on_r;
    show_dash_nxt_s = show_dash_r;
    error_nxt_s     = error_r;
    bc_start_nxt_s  = 1'b0;
    bs_start_nxt_s  = 1'b0;
    busy_nxt_s      = 1'b0;
    res_valid_nxt_s = 1'b0;

    case (state_r)
      S_IDLE, S_ERROR: begin
        if (start_edge_s) begin
          mode_q_nxt_s = mode;
          eng_a_nxt_s  = data_in;
          error_nxt_s  = 1'b0;
          cnt_nxt_s    = '0;
          state_nxt_s  = S_DISPATCH;
        end else begin
          state_nxt_s  = state_r;
        end
      end
      S_DISPATCH: begin
        cnt_nxt_s   = '0;
        state_nxt_s = S_RUN;
      end
      S_RUN: begin
        // done is checked before the budget, so a done on the last cycle wins.
        if (sel_done_s) begin
          if (!mode_q_r) begin
            hex0_nxt_s      = bc_result[3:0];
            hex1_on_nxt_s   = 1'b0;
            show_dash_nxt_s = 1'b0;
          end else if (bs_found) begin
            hex1_nxt_s      = {3'b000, bs_loc[4]};
            hex0_nxt_s      = bs_loc[3:0];
            hex1_on_nxt_s   = 1'b1;
            show_dash_nxt_s = 1'b0;
          end else begin
            hex1_on_nxt_s   = 1'b1;
            show_dash_nxt_s = 1'b1;
          end
          state_nxt_s = S_HOLD;
        end else if (cnt_r == TO_LAST) begin
          error_nxt_s     = 1'b1;
          show_dash_nxt_s = 1'b1;
          state_nxt_s     = S_ERROR;
        end else begin
          cnt_nxt_s = cnt_r + {{(TO_W-1){1'b0}}, 1'b1};
        end
      end
      S_HOLD: begin
        // Engines sit in their done-wait state until the start level drops.
        if (start_req) begin
          state_nxt_s = S_HOLD;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      default: begin
        state_nxt_s = S_IDLE;
      end
    endcase

    busy_nxt_s      = (state_nxt_s == S_DISPATCH) || (state_nxt_s == S_RUN);
    res_valid_nxt_s = (state_nxt_s == S_HOLD);
    if ((state_nxt_s == S_RUN) || (state_nxt_s == S_HOLD)) begin
      bc_start_nxt_s = ~mode_q_nxt_s;
      bs_start_nxt_s = mode_q_nxt_s;
    end else begin
      bc_start_nxt_s = 1'b0;
      bs_start_nxt_s = 1'b0;
    end
  end

  assign eng_a     = eng_a_r;
  assign bc_start  = bc_start_r;
  assign bs_start  = bs_start_r;
  assign busy      = busy_r;
  assign res_valid = res_valid_r;
  assign hex0_val  = hex0_r;
  assign hex1_val  = hex1_r;
  assign hex1_on   = hex1_on_r;
  assign show_dash = show_dash_r;
  assign error     = error_r;

endmodule
